unary_add_driver: RTL
=====================

UNARY_ADD_DRIVER -- requirements
Module: unary_add_driver

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  operand pair offered.
REQ-004 in_ready  output  1  driver can accept operands; high only in IDLE.
REQ-005 op_a, op_b  input  4 each  binary operands, 0..15.
REQ-006 en  output  1  enable to unary adder.
REQ-007 read_or_write  output  1  adder phase select: 0 = read (accumulate), 1 = write (drain).
REQ-008 a_out, b_out  output  1 each  unary operand streams to adder A/B.
REQ-009 dout_in  input  1  unary result stream from adder.
REQ-010 c_in  input  1  carry pulse from adder.
REQ-011 res_valid  output  1  one-cycle pulse, result valid.
REQ-012 res_sum  output  5  {carry, low 4 bits}; holds until next accept.
REQ-013 err  output  1  self-check mismatch; see Configuration.

Function
REQ-014 The FSM SHALL have states IDLE, READ, FLUSH, WRITE and DONE.
REQ-015 Accept: in IDLE with in_valid=1, the driver SHALL latch op_a/op_b, clear carry_sticky, pulse count and err, and enter READ.
- Both operands zero: enter FLUSH instead of READ.
REQ-016 READ lasts max(op_a,op_b) cycles, with read_or_write=0 and en=1.
- a_out=1 in the first op_a cycles; b_out=1 in the first op_b cycles; both start together.
REQ-017 FLUSH lasts exactly 2 cycles: en=1, read_or_write=0, a_out=b_out=0. It lets the adder's registered carry emerge.
REQ-018 WRITE: en=1, read_or_write=1, a_out=b_out=0.
- Every cycle with dout_in=1 SHALL increment the 5-bit pulse count.
REQ-019 WRITE exit: on the first WRITE cycle at index 2 or later (1-based) where dout_in=0.
- Forced exit after 17 WRITE cycles (timeout).
- Either exit goes to DONE.
REQ-020 carry_sticky SHALL set on c_in=1 in any READ cycle, FLUSH cycle, or the first WRITE cycle; c_in is ignored elsewhere.
REQ-021 DONE lasts 1 cycle, then returns to IDLE.
- res_valid=1 in DONE.
- res_sum = {carry_sticky, pulse count[3:0]}.
- en=0 in DONE.
REQ-022 In IDLE and DONE: en=0, a_out=b_out=0, read_or_write=0.
REQ-023 in_valid outside IDLE SHALL be ignored. Operands are not queued.
REQ-024 Pulse count SHALL saturate at 16. The adder never drains more than 15 pulses, so reaching 16 counts as a protocol error when checking is enabled.
REQ-025 Latency from accept to res_valid SHALL be max(op_a,op_b) + 2 + W + 1 cycles, where W is the number of WRITE cycles.

Reset
REQ-026 On rst_n=0, at any time including mid-operation, the driver SHALL immediately go to IDLE with the following values:
- en=0, read_or_write=0, a_out=b_out=0.
- res_valid=0, res_sum=0, err=0, in_ready=1.
- All internal counters and latched operands cleared.
REQ-027 After reset release, the first accept is possible on the first rising edge with in_valid=1.

Configuration
REQ-028 Macro UNARY_DRV_CHECK_EN defined:
- In DONE, err SHALL be set if res_sum != op_a+op_b, or if the pulse count reached 16.
- err holds until the next accept or reset.
REQ-029 Macro UNARY_DRV_CHECK_EN undefined: err SHALL be constant 0 and no comparator is built.

Verification
The bench uses a behavioural adder model: 4-bit count mod 16, C pulse 2 cycles after overflow, registered dout.
REQ-030 op_a=3, op_b=4 -> READ 4 cycles, a_out high 3 cycles, b_out high 4 cycles; res_sum=7, err=0.
REQ-031 op_a=15, op_b=15 -> carry captured; res_sum=5'b11110 (30), err=0.
REQ-032 op_a=8, op_b=8 -> no dout pulses, exit at WRITE cycle 2; res_sum=16.
REQ-033 op_a=0, op_b=0 -> READ skipped, FLUSH 2 cycles, WRITE 2 cycles; res_sum=0; total latency 5 cycles.
REQ-034 rst_n pulsed low in the 2nd WRITE cycle of 5+5 -> next edge sees en=0 and in_ready=1; a new 1+1 then yields res_sum=2.
REQ-035 With UNARY_DRV_CHECK_EN defined, the model is forced to drop one dout pulse on 6+2 -> res_sum=7, err=1.

Source files
------------

// File: rtl/unary_add_driver.sv
// Converts a binary operand pair into unary streams for a unary adder and collects its result.
// Optional self-check of the drained result is built when UNARY_DRV_CHECK_EN is defined.
module unary_add_driver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] op_a,
  input  logic [3:0] op_b,
  output logic       en,
  output logic       read_or_write,
  output logic       a_out,
  output logic       b_out,
  input  logic       dout_in,
  input  logic       c_in,
  output logic       res_valid,
  output logic [4:0] res_sum,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, READ, FLUSH, WRITE, DONE} state_t;

  state_t     state;
  logic [3:0] a_q, b_q;
  logic [4:0] step;
  logic [4:0] pulse_cnt;
  logic       carry_sticky;

  logic [3:0] max_ab;
  logic [4:0] step_inc;
  logic       carry_window;
  logic       carry_next;
  logic [4:0] cnt_next;
  logic       write_exit;
  logic [4:0] sum_next;

  assign max_ab   = (a_q > b_q) ? a_q : b_q;
  assign step_inc = step + 5'd1;

  // The adder's carry may trail the last operand pulse into the first WRITE cycle.
  assign carry_window = (state == READ) || (state == FLUSH) ||
                        ((state == WRITE) && (step == 5'd0));
  assign carry_next   = carry_sticky | (carry_window & c_in);

  assign cnt_next   = ((state == WRITE) && dout_in && (pulse_cnt != 5'd16)) ?
                      pulse_cnt + 5'd1 : pulse_cnt;
  // dout is registered in the adder, so the first WRITE cycle is always 0.
  assign write_exit = ((step != 5'd0) && !dout_in) || (step == 5'd16);
  assign sum_next   = {carry_next, cnt_next[3:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      step          <= '0;
      pulse_cnt     <= '0;
      carry_sticky  <= 1'b0;
      in_ready      <= 1'b1;
      en            <= 1'b0;
      read_or_write <= 1'b0;
      a_out         <= 1'b0;
      b_out         <= 1'b0;
      res_valid     <= 1'b0;
      res_sum       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q           <= op_a;
            b_q           <= op_b;
            carry_sticky  <= 1'b0;
            pulse_cnt     <= '0;
            res_sum       <= '0;
            step          <= '0;
            in_ready      <= 1'b0;
            en            <= 1'b1;
            read_or_write <= 1'b0;
            a_out         <= (op_a != 4'd0);
            b_out         <= (op_b != 4'd0);
            state         <= ((op_a == 4'd0) && (op_b == 4'd0)) ? FLUSH : READ;
          end
        end
        READ: begin
          carry_sticky <= carry_next;
          if (step_inc == {1'b0, max_ab}) begin
            state <= FLUSH;
            step  <= '0;
            a_out <= 1'b0;
            b_out <= 1'b0;
          end else begin
            step  <= step_inc;
            a_out <= (step_inc < {1'b0, a_q});
            b_out <= (step_inc < {1'b0, b_q});
          end
        end
        FLUSH: begin
          carry_sticky <= carry_next;
          if (step == 5'd1) begin
            state         <= WRITE;
            step          <= '0;
            read_or_write <= 1'b1;
          end else begin
            step <= step_inc;
          end
        end
        WRITE: begin
          carry_sticky <= carry_next;
          pulse_cnt    <= cnt_next;
          if (write_exit) begin
            state         <= DONE;
            en            <= 1'b0;
            read_or_write <= 1'b0;
            res_valid     <= 1'b1;
            res_sum       <= sum_next;
          end else begin
            step <= step_inc;
          end
        end
        DONE: begin
          res_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UNARY_DRV_CHECK_EN
  logic [4:0] expect_sum;
  logic       err_next;

  // A count of 16 means the adder drained more than it can hold.
  assign expect_sum = {1'b0, a_q} + {1'b0, b_q};
  assign err_next   = (sum_next != expect_sum) || cnt_next[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((state == IDLE) && in_valid) begin
      err <= 1'b0;
    end else if ((state == WRITE) && write_exit) begin
      err <= err_next;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
